tx_sequencer: RTL and testbench
===============================

// Module: tx_sequencer
// PURPOSE
//  Parametrised successor of the per-event ADC readout token manager. Takes aligned L1A
//  triggers, queues accepted events and passes a one-hot start_read token across N_CH ADC
//  channels, skipping masked channels. Counts transmitted and dropped events and keeps
//  sticky error flags. Sits between the L1A alignment logic and the per-ADC readout engines.
// PARAMETERS
//  N_CH    16  number of ADC channels (token width), 2..32
//  EVT_W   16  width of evt_tx and evt_drop counters
//  QDEPTH  4   max pending accepted events (counter-based queue), 1..15
//  TO_W    12  width of the timeout limit and counter (used only with TX_TIMEOUT_EN)
// PORTS
//  clk          in   1        system clock
//  reset_n      in   1        reset; asynchronous, active-low
//  l1a_align    in   1        one-cycle pulse: aligned L1A, event checked
//  need_read    in   1        sampled with l1a_align; 1 = event must be read out
//  ch_mask      in   N_CH     1 = channel enabled; latched at event start
//  ch_done      in   1        one-cycle pulse: current token holder finished reading
//  err_clr      in   1        clears the sticky error bits
//  timeout_lim  in   TO_W     per-channel watchdog limit; 0 = disabled
//  start_read   out  N_CH     one-hot token; all-zero when idle
//  busy         out  1        1 while an event is being read out (state ACTIVE)
//  q_level      out  4        number of pending queued events, 0..QDEPTH
//  evt_tx       out  EVT_W    completed events; wraps modulo 2^EVT_W
//  evt_drop     out  EVT_W    events lost to queue overflow; saturates at all-ones
//  error        out  5        sticky: [0] L1A w/o need_read, [1] queue overflow,
//                             [2] empty mask, [3] spurious ch_done, [4] channel timeout
// BEHAVIOUR
//  - Reset (reset_n=0, async): start_read=0, busy=0, q_level=0, evt_tx=0, evt_drop=0,
//    error=0, state=IDLE, internal mask and timer cleared.
//  - Enqueue, on l1a_align: need_read=0 -> set error[0], nothing queued. need_read=1 with
//    q_level==QDEPTH (after any same-cycle dequeue) -> set error[1], evt_drop+1. Otherwise
//    q_level+1.
//  - Same-cycle enqueue and dequeue: q_level unchanged.
//  - Dequeue rule: a dequeue occurs only in IDLE with q_level>0; that cycle's enqueue is
//    visible in q_level one cycle later.
//  - IDLE: with q_level>0, dequeue and latch ch_mask. Latched mask nonzero ->
//    start_read = lowest set mask bit next cycle, busy=1, go to ACTIVE. Mask zero -> set
//    error[2], event discarded (no evt_tx change), stay in IDLE.
//  - ACTIVE: on ch_done, the token moves to the next higher set bit of the latched mask on
//    the next cycle. No higher bit -> start_read=0, busy=0, evt_tx+1, go to IDLE. Earliest
//    start of the next event is the cycle after that.
//  - Latency: l1a_align at cycle t with empty queue and IDLE -> start_read valid at t+2.
//  - Back-to-back: the token advances on consecutive ch_done pulses, one channel per pulse.
//  - ch_done while IDLE: set error[3], ignored.
//  - ch_mask changes during ACTIVE have no effect until the next event start.
//  - err_clr clears error[4:0]; an error set in the same cycle wins, so that bit stays 1.
//  - Counters wrap (evt_tx) or saturate (evt_drop) with no error flag.
// CONFIGURATION
//  TX_TIMEOUT_EN defined:
//  - In ACTIVE, a TO_W-bit timer counts cycles since the token moved.
//  - If timeout_lim!=0 and the timer reaches timeout_lim without ch_done: set error[4] and
//    advance the token exactly as for ch_done. The timer restarts on every token move.
//  TX_TIMEOUT_EN undefined:
//  - No timer logic; timeout_lim ignored; error[4] constant 0.
// TESTING
//  1. N_CH=16, mask=FFFF, one L1A with need_read=1, ch_done every 3 cycles -> token
//     0001..8000 in order, evt_tx=1, busy low after 16th done.
//  2. mask=0x0A05, one event -> token visits bits 0,2,9,11 only; evt_tx=1, error=0.
//  3. QDEPTH=4, six L1As while ACTIVE on a long event -> q_level=4, evt_drop=2,
//     error[1]=1; all 5 accepted events later complete, evt_tx=5.
//  4. l1a with need_read=0 -> error=5'b00001; ch_done in IDLE -> error=5'b01001;
//     err_clr -> error=0.
//  5. mask=0 at event start -> error[2]=1, evt_tx unchanged, q_level decrements.
//  6. TX_TIMEOUT_EN, timeout_lim=10, no ch_done on channel 3 -> token leaves bit 3 after
//     10 cycles, error[4]=1. Without macro: token holds on bit 3 and error[4]=0.
//     reset_n low mid-event -> all outputs 0 immediately.

Source files
------------

// File: rtl/tx_sequencer.sv
// tx_sequencer: queues accepted L1A events and passes a one-hot start_read token across
// the enabled ADC channels. Optional per-channel watchdog enabled by defining TX_TIMEOUT_EN.
module tx_sequencer #(
  parameter int N_CH   = 16,
  parameter int EVT_W  = 16,
  parameter int QDEPTH = 4,
  parameter int TO_W   = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             l1a_align,
  input  logic             need_read,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic             ch_done,
  input  logic             err_clr,
  input  logic [TO_W-1:0]  timeout_lim,
  output logic [N_CH-1:0]  start_read,
  output logic             busy,
  output logic [3:0]       q_level,
  output logic [EVT_W-1:0] evt_tx,
  output logic [EVT_W-1:0] evt_drop,
  output logic [4:0]       error
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [3:0]       QD     = 4'(QDEPTH);
  localparam logic [N_CH-1:0]  ZERO_N = {N_CH{1'b0}};
  localparam logic [N_CH-1:0]  ONE_N  = {{(N_CH-1){1'b0}}, 1'b1};
  localparam logic [EVT_W-1:0] ONE_E  = {{(EVT_W-1){1'b0}}, 1'b1};
  localparam logic [EVT_W-1:0] SAT_E  = {EVT_W{1'b1}};

  function automatic logic [N_CH-1:0] lowest_bit(input logic [N_CH-1:0] v);
    return v & (~v + ONE_N);
  endfunction

  // Lowest mask bit strictly above the one-hot token; zero when none remains.
  function automatic logic [N_CH-1:0] next_bit(input logic [N_CH-1:0] m,
                                               input logic [N_CH-1:0] tok);
    logic [N_CH-1:0] above;
    above = m & ~((tok << 1'b1) - ONE_N);
    return lowest_bit(above);
  endfunction

  state_t           state_r, state_s;
  logic [N_CH-1:0]  tok_r, tok_s, mask_r, mask_s, nxt_tok_s;
  logic             busy_r, deq_s, adv_s;
  logic [3:0]       q_r, q_s, avail_s;
  logic [EVT_W-1:0] tx_r, tx_s, drop_r, drop_s;
  logic [4:0]       err_r, err_s, err_set_s;
  logic             timeout_s, to_err_s;

`ifdef TX_TIMEOUT_EN
  localparam logic [TO_W-1:0] ONE_T = {{(TO_W-1){1'b0}}, 1'b1};
  logic [TO_W-1:0] timer_r, timer_s;

  // Watchdog: counts cycles the token has rested on one channel
  always_comb begin
    timeout_s = (state_r == ACTIVE) && (timeout_lim != {TO_W{1'b0}}) &&
                (timer_r == timeout_lim - ONE_T);
    to_err_s  = timeout_s & ~ch_done;
    if ((state_r == ACTIVE) && !(ch_done || timeout_s)) begin
      timer_s = timer_r + ONE_T;
    end else begin
      timer_s = {TO_W{1'b0}};
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_r <= {TO_W{1'b0}};
    end else begin
      timer_r <= timer_s;
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^timeout_lim;
  assign timeout_s        = 1'b0;
  assign to_err_s         = 1'b0;
`endif

  // Next-state, token, queue, counter and error logic
  always_comb begin
    state_s   = state_r;
    tok_s     = tok_r;
    mask_s    = mask_r;
    tx_s      = tx_r;
    drop_s    = drop_r;
    err_set_s = 5'b00000;
    deq_s     = 1'b0;
    adv_s     = ch_done | timeout_s;
    nxt_tok_s = next_bit(mask_r, tok_r);
    case (state_r)
      IDLE: begin
        err_set_s[3] = ch_done;
        if (q_r != 4'd0) begin
          deq_s  = 1'b1;
          mask_s = ch_mask;
          if (ch_mask != ZERO_N) begin
            tok_s   = lowest_bit(ch_mask);
            state_s = ACTIVE;
          end else begin
            tok_s        = ZERO_N;
            err_set_s[2] = 1'b1;
          end
        end else begin
          tok_s = ZERO_N;
        end
      end
      ACTIVE: begin
        if (adv_s) begin
          if (nxt_tok_s != ZERO_N) begin
            tok_s = nxt_tok_s;
          end else begin
            tok_s   = ZERO_N;
            state_s = IDLE;
            tx_s    = tx_r + ONE_E;
          end
        end else begin
          tok_s = tok_r;
        end
      end
      default: begin
        state_s = IDLE;
        tok_s   = ZERO_N;
      end
    endcase

    // Overflow is judged against the level left after this cycle's dequeue.
    avail_s = q_r - {3'b000, deq_s};
    if (l1a_align && need_read) begin
      if (avail_s == QD) begin
        q_s          = avail_s;
        err_set_s[1] = 1'b1;
        drop_s       = (drop_r == SAT_E) ? drop_r : drop_r + ONE_E;
      end else begin
        q_s = avail_s + 4'd1;
      end
    end else if (l1a_align) begin
      q_s          = avail_s;
      err_set_s[0] = 1'b1;
    end else begin
      q_s = avail_s;
    end
    err_set_s[4] = to_err_s;
    err_s = (err_clr ? 5'b00000 : err_r) | err_set_s;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      tok_r   <= ZERO_N;
      mask_r  <= ZERO_N;
      busy_r  <= 1'b0;
      q_r     <= 4'd0;
      tx_r    <= {EVT_W{1'b0}};
      drop_r  <= {EVT_W{1'b0}};
      err_r   <= 5'b00000;
    end else begin
      state_r <= state_s;
      tok_r   <= tok_s;
      mask_r  <= mask_s;
      busy_r  <= (state_s == ACTIVE);
      q_r     <= q_s;
      tx_r    <= tx_s;
      drop_r  <= drop_s;
      err_r   <= err_s;
    end
  end

  assign start_read = tok_r;
  assign busy       = busy_r;
  assign q_level    = q_r;
  assign evt_tx     = tx_r;
  assign evt_drop   = drop_r;
  assign error      = err_r;

endmodule

// File: tb/tb_tx_sequencer.sv
// Self-checking bench for tx_sequencer: vector table, directed corner sequences and
// randomized traffic against an event-list reference model.
module tb_tx_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        l1a_align = 1'b0;
  logic        need_read = 1'b0;
  logic [15:0] ch_mask = 16'h0000;
  logic        ch_done = 1'b0;
  logic        err_clr = 1'b0;
  logic [11:0] timeout_lim = 12'd0;
  logic [15:0] start_read;
  logic        busy;
  logic [3:0]  q_level;
  logic [15:0] evt_tx;
  logic [15:0] evt_drop;
  logic [4:0]  error;

  tx_sequencer #(.N_CH(16), .EVT_W(16), .QDEPTH(4), .TO_W(12)) dut (
    .clk(clk), .reset_n(reset_n), .l1a_align(l1a_align), .need_read(need_read),
    .ch_mask(ch_mask), .ch_done(ch_done), .err_clr(err_clr), .timeout_lim(timeout_lim),
    .start_read(start_read), .busy(busy), .q_level(q_level), .evt_tx(evt_tx),
    .evt_drop(evt_drop), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending count plus list of channels left in the current event
  int          m_pend = 0;
  bit          m_active = 1'b0;
  int          m_chans[$];
  logic [15:0] m_tx = 16'd0;
  logic [15:0] m_drop = 16'd0;
  logic [4:0]  m_err = 5'd0;
  bit          model_on = 1'b1;

  typedef struct {
    bit          l1a;
    bit          need;
    logic [15:0] mask;
    bit          done;
    bit          clr;
    logic [15:0] e_start;
    bit          e_busy;
    logic [3:0]  e_q;
    logic [4:0]  e_err;
    logic [15:0] e_tx;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_tick(input bit l1a, input bit need, input logic [15:0] mask,
                            input bit done, input bit clr);
    logic [4:0] set;
    int avail;
    int deq;
    set = 5'b0;
    deq = 0;
    if (m_active) begin
      if (done) begin
        void'(m_chans.pop_front());
        if (m_chans.size() == 0) begin
          m_active = 1'b0;
          m_tx = m_tx + 16'd1;
        end
      end
    end else begin
      if (done) set[3] = 1'b1;
      if (m_pend > 0) begin
        deq = 1;
        for (int c = 0; c < 16; c++) if (mask[c]) m_chans.push_back(c);
        if (m_chans.size() == 0) set[2] = 1'b1;
        else m_active = 1'b1;
      end
    end
    avail = m_pend - deq;
    if (l1a && !need) set[0] = 1'b1;
    if (l1a && need) begin
      if (avail == 4) begin
        set[1] = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end else begin
        avail = avail + 1;
      end
    end
    m_pend = avail;
    m_err = (clr ? 5'b0 : m_err) | set;
  endtask

  task automatic compare_model();
    logic [15:0] exp_tok;
    exp_tok = 16'h0000;
    if (m_active) exp_tok = 16'h0001 << m_chans[0];
    check("model start_read", start_read, exp_tok);
    check("model busy", busy, m_active);
    check("model q_level", q_level, m_pend);
    check("model evt_tx", evt_tx, m_tx);
    check("model evt_drop", evt_drop, m_drop);
    check("model error", error, m_err);
  endtask

  task automatic step(input bit l1a, input bit need, input logic [15:0] mask,
                      input bit done, input bit clr);
    l1a_align = l1a;
    need_read = need;
    ch_mask   = mask;
    ch_done   = done;
    err_clr   = clr;
    @(posedge clk);
    model_tick(l1a, need, mask, done, clr);
    #1;
    if (model_on) compare_model();
  endtask

  task automatic do_reset();
    l1a_align = 1'b0;
    need_read = 1'b0;
    ch_mask   = 16'h0000;
    ch_done   = 1'b0;
    err_clr   = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("rst start_read", start_read, 16'h0000);
    check("rst busy", busy, 1'b0);
    check("rst q_level", q_level, 4'd0);
    check("rst evt_tx", evt_tx, 16'd0);
    check("rst evt_drop", evt_drop, 16'd0);
    check("rst error", error, 5'd0);
    m_pend = 0;
    m_active = 1'b0;
    m_chans.delete();
    m_tx = 16'd0;
    m_drop = 16'd0;
    m_err = 5'd0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int exp_q[6];
    logic [15:0] tx0;
    int cnt;
    bit r_l1a, r_need, r_done, r_clr;
    logic [15:0] r_mask;

    //            l1a need mask     done clr start    busy q     err       tx
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 5'b00001, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 5'b01001, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd0, 5'b00000, 16'd0};
    tbl[3]  = '{1'b1, 1'b1, 16'h0A05, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd1, 5'b00000, 16'd0};
    tbl[4]  = '{1'b0, 1'b0, 16'h0A05, 1'b0, 1'b0, 16'h0001, 1'b1, 4'd0, 5'b00000, 16'd0};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004, 1'b1, 4'd0, 5'b00000, 16'd0};
    tbl[6]  = '{1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0004, 1'b1, 4'd0, 5'b00000, 16'd0};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 1'b1, 4'd0, 5'b00000, 16'd0};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0800, 1'b1, 4'd0, 5'b00000, 16'd0};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 5'b00000, 16'd1};
    tbl[10] = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd1, 5'b00000, 16'd1};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 5'b00100, 16'd1};
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd0, 5'b00001, 16'd1};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd0, 5'b00000, 16'd1};
    exp_q = '{1, 2, 3, 4, 4, 4};

    #2;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].l1a, tbl[i].need, tbl[i].mask, tbl[i].done, tbl[i].clr);
      check($sformatf("vec%0d start_read", i), start_read, tbl[i].e_start);
      check($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
      check($sformatf("vec%0d q_level", i), q_level, tbl[i].e_q);
      check($sformatf("vec%0d error", i), error, tbl[i].e_err);
      check($sformatf("vec%0d evt_tx", i), evt_tx, tbl[i].e_tx);
    end

    // Full mask, ch_done every third cycle
    tx0 = evt_tx;
    step(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
      check($sformatf("walk tok%0d hold", i), start_read, 16'h0001 << i);
      step(1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
      step(1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      check($sformatf("walk tok%0d next", i), start_read,
            (i < 15) ? (16'h0001 << (i + 1)) : 16'h0000);
    end
    check("walk busy", busy, 1'b0);
    check("walk evt_tx", evt_tx, tx0 + 16'd1);

    // Asynchronous reset in the middle of an event
    step(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    #2;
    do_reset();

    // Queue overflow while a long event is active
    step(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      check($sformatf("ovf q_level %0d", i), q_level, exp_q[i]);
    end
    check("ovf evt_drop", evt_drop, 16'd2);
    check("ovf error", error, 5'b00010);
    for (int k = 0; k < 400 && (m_active || m_pend > 0); k++) begin
      step(1'b0, 1'b0, 16'hFFFF, m_active, 1'b0);
    end
    check("drain evt_tx", evt_tx, 16'd5);
    check("drain q_level", q_level, 4'd0);
    check("drain busy", busy, 1'b0);
    check("drain error", error, 5'b00010);

    // Channel watchdog on bit 3 (mask bits 3 and 4)
    do_reset();
    model_on = 1'b0;
    timeout_lim = 12'd10;
    step(1'b1, 1'b1, 16'h0018, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0018, 1'b0, 1'b0);
    check("wd first token", start_read, 16'h0008);
    cnt = 1;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 1'b0, 16'h0018, 1'b0, 1'b0);
      if (start_read != 16'h0008) break;
      cnt++;
    end
`ifdef TX_TIMEOUT_EN
    check("wd hold cycles", cnt, 10);
    check("wd next token", start_read, 16'h0010);
    check("wd error4", error[4], 1'b1);
`else
    check("wd hold cycles", cnt, 31);
    check("wd token held", start_read, 16'h0008);
    check("wd error4", error[4], 1'b0);
`endif
    timeout_lim = 12'd0;
    do_reset();
    model_on = 1'b1;

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      r_l1a  = ($urandom_range(0, 4) == 0);
      r_need = ($urandom_range(0, 7) != 0);
      r_done = ($urandom_range(0, 1) == 0);
      r_clr  = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: r_mask = 16'h0000;
        1: r_mask = 16'($urandom);
        2: r_mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: r_mask = 16'h0001 << $urandom_range(0, 15);
      endcase
      step(r_l1a, r_need, r_mask, r_done, r_clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
